// File: rtl/burst_sequencer.sv
// Gated carrier burst generator feeding the per-speaker phase shifters.
// Optional soft start ramp on the duty cycle is enabled with BURST_SOFT_RAMP_EN.
module burst_sequencer #(
    parameter int STEPS       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk0_64,
    input  logic       speakersOn_clr,
    input  logic       start_req,
    input  logic [3:0] duty,
    input  logic [3:0] burst_len,
    input  logic [3:0] holdoff,
    output logic       base_out,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [3:0] period_idx
);
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CMP_W  = STEP_W + 6;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                r_edge;
    logic                w_start_edge;
    logic [STEP_W-1:0]   r_step, w_step_nxt, w_step_inc;
    logic [3:0]          r_period, w_period_nxt, w_period_inc;
    logic [3:0]          r_duty_lat, w_duty_lat_nxt;
    logic [4:0]          r_len_lat, w_len_lat_nxt;
    logic [3:0]          r_hold_lat, w_hold_lat_nxt;
    logic [7:0]          r_hold_cnt, w_hold_cnt_nxt, w_hold_last;
    logic                r_base, w_base_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic                w_last_period;
    logic [5:0]          w_eff_start, w_eff_cur, w_eff_next;

    // Carrier is high while the step index is below the effective duty.
    function automatic logic f_on(input logic [STEP_W-1:0] s, input logic [5:0] eff);
        return CMP_W'(s) < CMP_W'(eff);
    endfunction

`ifdef BURST_SOFT_RAMP_EN
    // Duty limited to 2*(p+1) so the transducers see a gradual inrush.
    function automatic logic [5:0] f_ramp_cap(input logic [3:0] d, input logic [3:0] p);
        logic [5:0] ramp;
        ramp = ({2'b00, p} + 6'd1) << 1;
        if ({2'b00, d} < ramp) begin
            return {2'b00, d};
        end else begin
            return ramp;
        end
    endfunction

    assign w_eff_start = f_ramp_cap(duty, 4'd0);
    assign w_eff_cur   = f_ramp_cap(r_duty_lat, r_period);
    assign w_eff_next  = f_ramp_cap(r_duty_lat, w_period_inc);
`else
    assign w_eff_start = {2'b00, duty};
    assign w_eff_cur   = {2'b00, r_duty_lat};
    assign w_eff_next  = {2'b00, r_duty_lat};
`endif

    assign w_start_edge  = r_sync[SYNC_STAGES-1] & ~r_edge;
    assign w_step_inc    = r_step + 1'b1;
    assign w_period_inc  = r_period + 4'd1;
    assign w_last_period = ({1'b0, r_period} == (r_len_lat - 5'd1));
    assign w_hold_last   = 8'(r_hold_lat * STEPS) - 8'd1;

    // Start request synchroniser and rising-edge register.
    always_ff @(posedge clk0_64 or negedge speakersOn_clr) begin
        if (!speakersOn_clr) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], start_req};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk0_64 or negedge speakersOn_clr) begin
        if (!speakersOn_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_period_nxt   = r_period;
        w_duty_lat_nxt = r_duty_lat;
        w_len_lat_nxt  = r_len_lat;
        w_hold_lat_nxt = r_hold_lat;
        w_hold_cnt_nxt = r_hold_cnt;
        w_base_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_overrun_nxt  = r_overrun;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt   = 1'b0;
                w_period_nxt = 4'd0;
                if (w_start_edge) begin
                    w_duty_lat_nxt = duty;
                    w_len_lat_nxt  = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
                    w_hold_lat_nxt = holdoff;
                    w_step_nxt     = STEP_ZERO;
                    w_overrun_nxt  = 1'b0;
                    w_base_nxt     = f_on(STEP_ZERO, w_eff_start);
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_BURST;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BURST: begin
                w_busy_nxt = 1'b1;
                w_step_nxt = w_step_inc;
                if (w_start_edge) begin
                    w_overrun_nxt = 1'b1;
                end else begin
                    w_overrun_nxt = r_overrun;
                end
                if (r_step == STEP_LAST) begin
                    if (w_last_period) begin
                        w_done_nxt     = 1'b1;
                        w_period_nxt   = 4'd0;
                        w_hold_cnt_nxt = 8'd0;
                        if (r_hold_lat != 4'd0) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_period_nxt = w_period_inc;
                        w_base_nxt   = f_on(STEP_ZERO, w_eff_next);
                    end
                end else begin
                    w_base_nxt = f_on(w_step_inc, w_eff_cur);
                end
            end
            S_HOLD: begin
                w_step_nxt = w_step_inc;
                if (w_start_edge) begin
                    w_overrun_nxt = 1'b1;
                end else begin
                    w_overrun_nxt = r_overrun;
                end
                if (r_hold_cnt == w_hold_last) begin
                    w_hold_cnt_nxt = 8'd0;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                    w_busy_nxt     = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_busy_nxt   = 1'b0;
                w_period_nxt = 4'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk0_64 or negedge speakersOn_clr) begin
        if (!speakersOn_clr) begin
            r_step     <= STEP_ZERO;
            r_period   <= 4'd0;
            r_duty_lat <= 4'd0;
            r_len_lat  <= 5'd0;
            r_hold_lat <= 4'd0;
            r_hold_cnt <= 8'd0;
            r_base     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_step     <= w_step_nxt;
            r_period   <= w_period_nxt;
            r_duty_lat <= w_duty_lat_nxt;
            r_len_lat  <= w_len_lat_nxt;
            r_hold_lat <= w_hold_lat_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_base     <= w_base_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign base_out   = r_base;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;
    assign period_idx = r_period;
endmodule

// File: tb/tb_burst_sequencer.sv
// Scoreboard bench for burst_sequencer: stimulus pushes expected bursts,
// a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_burst_sequencer;
    localparam int STEPS = 16;

    logic       clk0_64 = 1'b0;
    logic       speakersOn_clr;
    logic       start_req;
    logic [3:0] duty, burst_len, holdoff;
    logic       base_out, busy, done, overrun;
    logic [3:0] period_idx;

    always #5 clk0_64 = ~clk0_64;

    burst_sequencer #(.STEPS(STEPS), .SYNC_STAGES(2)) dut (
        .clk0_64(clk0_64), .speakersOn_clr(speakersOn_clr), .start_req(start_req),
        .duty(duty), .burst_len(burst_len), .holdoff(holdoff),
        .base_out(base_out), .busy(busy), .done(done), .overrun(overrun),
        .period_idx(period_idx)
    );

    typedef struct {
        int         start_cyc;
        int         len;
        int         hold;
        logic [255:0] pats;
        bit         ovr_done;
        bit         ovr_end;
    } rec_t;

    rec_t exp_q[$];
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int idle_pidx_err = 0;
    int hold_base_err = 0;

    always @(posedge clk0_64) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: high count of period p, limited by the optional ramp and the period.
    function automatic int eff_duty(input int d, input int p);
        int e;
        e = d;
`ifdef BURST_SOFT_RAMP_EN
        if (2 * (p + 1) < e) e = 2 * (p + 1);
`endif
        if (e > STEPS) e = STEPS;
        return e;
    endfunction

    function automatic logic [15:0] period_pat(input int e);
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < e; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk0_64);
    endtask

    // Monitor: 0 idle, 1 burst, 2 hold.
    initial begin : monitor
        int   mon, s, k, dcyc, pidx_err;
        rec_t r;
        logic [15:0] pv;
        mon = 0; s = 0; k = 0; dcyc = 0; pidx_err = 0; pv = 16'h0000;
        forever begin
            @(negedge clk0_64);
            if (speakersOn_clr !== 1'b1) begin
                mon = 0;
                continue;
            end
            if (mon == 0) begin
                if (period_idx !== 4'd0) idle_pidx_err++;
                if (done === 1'b1) chk("unexpected_done", 1, 0);
                if (busy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_burst", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        chk("busy_rise_cycle", cyc, r.start_cyc);
                        mon = 1; s = cyc; pidx_err = 0; pv = 16'h0000;
                    end
                end
            end
            if (mon == 1) begin
                k = cyc - s;
                if (done === 1'b1) begin
                    chk("burst_clocks", k, r.len * STEPS);
                    chk("overrun_at_done", overrun, r.ovr_done);
                    chk("period_idx_track", pidx_err, 0);
                    chk("busy_at_done", busy, (r.hold != 0));
                    dcyc = cyc;
                    if (r.hold != 0) begin
                        mon = 2;
                    end else begin
                        chk("overrun_at_end", overrun, r.ovr_end);
                        mon = 0;
                    end
                end else if (k >= r.len * STEPS || busy !== 1'b1) begin
                    chk("done_missing_at_clock", k, r.len * STEPS);
                    mon = 0;
                end else begin
                    pv[k % STEPS] = base_out;
                    if (period_idx !== 4'(k / STEPS)) pidx_err++;
                    if (k % STEPS == STEPS - 1)
                        chk($sformatf("period_%0d_pattern", k / STEPS), pv,
                            r.pats[(k / STEPS) * 16 +: 16]);
                end
            end else if (mon == 2) begin
                if (period_idx !== 4'd0) idle_pidx_err++;
                if (done === 1'b1) chk("done_in_hold", 1, 0);
                if (busy !== 1'b1) begin
                    chk("holdoff_clocks", cyc - dcyc, r.hold * STEPS);
                    chk("overrun_at_end", overrun, r.ovr_end);
                    mon = 0;
                end else begin
                    if (base_out !== 1'b0) hold_base_err++;
                    if (cyc - dcyc > r.hold * STEPS) begin
                        chk("holdoff_overlong", cyc - dcyc, r.hold * STEPS);
                        mon = 0;
                    end
                end
            end
        end
    end

    task automatic run_burst(input int d, input int l, input int h,
                             input bit rb, input bit rh, input bit rst_mid);
        rec_t r;
        int   le, budget;
        le = (l == 0) ? 16 : l;
        duty = 4'(d); burst_len = 4'(l); holdoff = 4'(h);
        start_req = 1'b1;
        r.start_cyc = cyc + 3;
        r.len = le; r.hold = h; r.ovr_done = rb; r.ovr_end = rb | rh;
        r.pats = '0;
        for (int p = 0; p < le; p++) r.pats[p * 16 +: 16] = period_pat(eff_duty(d, p));
        exp_q.push_back(r);
        tick(3);
        start_req = 1'b0;
        duty = 4'($urandom_range(0, 15));
        burst_len = 4'($urandom_range(0, 15));
        holdoff = 4'($urandom_range(0, 15));
        if (rb) begin
            tick(12); start_req = 1'b1; tick(3); start_req = 1'b0;
        end
        if (rst_mid) begin
            while (cyc < r.start_cyc + 2 * STEPS + 5) tick(1);
            speakersOn_clr = 1'b0;
            #1;
            chk("rst_async_base_out", base_out, 0);
            chk("rst_async_busy", busy, 0);
            chk("rst_async_done", done, 0);
            chk("rst_async_period_idx", period_idx, 0);
            tick(3);
            speakersOn_clr = 1'b1;
            tick(3);
            chk("rst_no_done", done, 0);
            return;
        end
        if (rh) begin
            budget = le * STEPS + 40;
            while (done !== 1'b1 && budget > 0) begin tick(1); budget--; end
            tick(4); start_req = 1'b1; tick(3); start_req = 1'b0;
        end
        budget = (le + h) * STEPS + 40;
        while (busy !== 1'b0 && budget > 0) begin tick(1); budget--; end
        if (budget == 0) chk("busy_fall_timeout", 1, 0);
        tick(2);
    endtask

    initial begin : stimulus
        speakersOn_clr = 1'b0; start_req = 1'b0;
        duty = 4'd0; burst_len = 4'd0; holdoff = 4'd0;
        tick(3);
        chk("reset_base_out", base_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_period_idx", period_idx, 0);
        speakersOn_clr = 1'b1;
        tick(2);

        run_burst(8, 4, 0, 0, 0, 0);
        run_burst(0, 1, 0, 0, 0, 0);
        run_burst(15, 1, 0, 0, 0, 0);
        run_burst(5, 0, 2, 0, 0, 0);
        run_burst(8, 4, 1, 1, 0, 0);
        run_burst(6, 2, 3, 0, 1, 0);
        run_burst(3, 2, 0, 0, 0, 0);
        run_burst(8, 4, 0, 0, 0, 1);
        run_burst(8, 5, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            run_burst($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 4), 0, 0, 0);

        tick(4);
        chk("queue_drained", exp_q.size(), 0);
        chk("period_idx_outside_burst", idle_pidx_err, 0);
        chk("base_out_in_hold", hold_base_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/burst_sequencer.md
# burst_sequencer

Generates the gated 40 kHz carrier burst (`base_out`) that feeds all 37 per-speaker phase shifters. It runs in the `clk0_64` domain. One step is one clock; one carrier period is `STEPS` clocks.
- A start request from the register-write domain is synchronised, then emits a programmable number of carrier periods at a programmable duty.
- It then enforces a hold-off window, pulses `done`, and returns to idle.
- It replaces the ad-hoc counter/pulse-counter logic in front of the phase shifters.

## Interface
Parameters:
- `STEPS`, default 16: clocks per carrier period (power of two). Step counter width is log2(`STEPS`).
- `SYNC_STAGES`, default 2: synchroniser depth for `start_req` (≥2).

Ports:
- `clk0_64` in 1: step clock (640 kHz nominal).
- `speakersOn_clr` in 1: reset, asynchronous, active-low; clock `clk0_64`.
- `start_req` in 1: start request, asynchronous to `clk0_64`. Only a rising edge is meaningful; it must be held high ≥2 `clk0_64` periods.
- `duty` in 4: high steps per period (0 = silent, 8 = 50 %). Latched at burst start.
- `burst_len` in 4: carrier periods per burst (0 = 16 periods). Latched at burst start.
- `holdoff` in 4: guard periods after the burst (0 = none). Latched at burst start.
- `base_out` out 1: registered carrier to the phase shifters.
- `busy` out 1: high in BURST and HOLD.
- `done` out 1: one-clock pulse at end of burst.
- `overrun` out 1: sticky flag, set when a start edge is dropped.
- `period_idx` out 4: current period index within the burst (0-based). Holds 0 outside BURST.

## Operation
- Synchroniser: `start_req` passes through `SYNC_STAGES` flops, then an edge register. `start_edge` = sync_out & ~edge_reg.
- States: IDLE, BURST, HOLD.
- IDLE:
  - On `start_edge`, latch `duty`, `burst_len`, `holdoff` into `duty_lat`, `len_lat` (0→16), `hold_lat`.
  - Clear `step`, `period_idx` and `overrun`, then go to BURST.
- BURST:
  - `step` increments 0..`STEPS`-1 and wraps. `period_idx` increments on each wrap.
  - `base_out` for the next clock = (next `step` < effective duty). Duty 0 gives constant low; duty ≥ `STEPS` gives constant high.
  - On wrap of the last period (`period_idx` = `len_lat`-1, `step` = `STEPS`-1): go to HOLD if `hold_lat`≠0, else go to IDLE. `done` pulses in either case.
- HOLD:
  - `base_out` = 0. `step` and a hold counter run for `hold_lat`×`STEPS` clocks, then go to IDLE.
- Start edges seen in BURST or HOLD are dropped, never queued, and set `overrun`.
- A start edge in the same clock as the HOLD→IDLE or BURST→IDLE transition is also dropped and sets `overrun`.
- Input changes on `duty`/`burst_len`/`holdoff` during a burst have no effect until the next start.
- Arithmetic: `step` is a width-log2(`STEPS`) wrap counter. `period_idx` is 4 bits with compare against `len_lat`-1 computed in 5 bits. The hold counter is 8 bits.

## Timing
- Reset (`speakersOn_clr`=0), effective immediately and asynchronously:
  - State IDLE.
  - `base_out`, `busy`, `done`, `overrun` = 0; `period_idx` = 0.
  - Synchroniser and edge flops = 0.
- Reset mid-burst truncates the output at once. There is no `done` pulse.
- Latency: the first `clk0_64` edge sampling `start_req` high is E0. The state is BURST after E(`SYNC_STAGES`). `base_out` is first high (if effective duty >0) in the cycle after E(`SYNC_STAGES`). `busy` rises on that same edge.
- Burst length: exactly `len_lat`×`STEPS` clocks of BURST. `base_out` is high for the first effective-duty clocks of each period.
- `done`: high for exactly one clock, the first clock after the last BURST clock. `busy` falls on that edge if `hold_lat`=0, otherwise `hold_lat`×`STEPS` clocks later.
- The earliest next accepted start edge is the first clock in IDLE.

## Configuration
- `BURST_SOFT_RAMP_EN`:
  - Defined: effective duty in period p = min(`duty_lat`, 2·(p+1)). With duty 8 this gives 2, 4, 6, 8, 8, …, which reduces transducer inrush.
  - Undefined: effective duty = `duty_lat` in every period. The ramp logic is not present.

## Test plan
- Reset, then `start_req` pulse (3 clocks), `duty`=8, `burst_len`=4, `holdoff`=0 → the following must all hold:
  - `busy` rises after 2 sync + 1 clocks.
  - 4 periods of 8 high / 8 low.
  - `done` one clock after the 64th BURST clock.
  - Back to IDLE.
- `duty`=0 then `duty`=15, `burst_len`=1 → `base_out` constant 0 for 16 clocks, then 15 high / 1 low. `done` fires in both cases.
- `burst_len`=0, `holdoff`=2 → 256 BURST clocks, then 32 HOLD clocks with `base_out`=0. `busy` falls 32 clocks after `done`.
- Second start edge mid-burst and mid-HOLD → no retrigger, `overrun`=1. The next accepted start clears `overrun`.
- Assert `speakersOn_clr` low during period 2 → `base_out`, `busy` go 0 without a clock edge, and no `done` is produced. After release, a new start works normally.
- With `BURST_SOFT_RAMP_EN` and `duty`=8, `burst_len`=5 → high counts per period are 2, 4, 6, 8, 8. Without the macro → 8, 8, 8, 8, 8.
